// File: rtl/pedo_pkg.sv
// Shared definitions for the weight-fetch stage: command encodings, FSM state
// encoding and the weight slot indices used by the load sequence.
package pedo_pkg;

  // Upstream command encodings carried on in_funct.
  typedef enum logic [2:0] {
    FnClr = 3'd0,
    FnCnt = 3'd1,
    FnUpd = 3'd2
  } funct_e;

  // Fetch-stage FSM states.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StIssue  = 2'd2,
    StWaitWb = 2'd3
  } state_e;

  // Weight slot indices, in the order a LOAD sequence writes them.
  localparam int unsigned NumWeights = 6;
  localparam logic [2:0] IdxTheta11 = 3'd0;
  localparam logic [2:0] IdxTheta12 = 3'd1;
  localparam logic [2:0] IdxTheta21 = 3'd2;
  localparam logic [2:0] IdxTheta22 = 3'd3;
  localparam logic [2:0] IdxAlpha1  = 3'd4;
  localparam logic [2:0] IdxAlpha2  = 3'd5;

endpackage

// File: rtl/weight_regfile.sv
// Six-entry weight register file with an indexed write port and a synchronous
// clear. Both rst and clr_i return every entry to W_RST.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   clr_i          synchronous clear of all entries to W_RST
//   we_i, idx_i    write enable and slot index (indices >= 6 are ignored)
//   wdata_i        write data
//   weights_o      all six entries, slot 0 in the low word
module weight_regfile
  import pedo_pkg::*;
#(
  parameter int unsigned     DW    = 10,
  parameter logic [DW-1:0]   W_RST = 10'd1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_i,
  input  logic                        we_i,
  input  logic [2:0]                  idx_i,
  input  logic [DW-1:0]               wdata_i,
  output logic [NumWeights-1:0][DW-1:0] weights_o
);

  logic [NumWeights-1:0][DW-1:0] weights_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      for (int i = 0; i < NumWeights; i++) begin
        weights_q[i] <= W_RST;
      end
    end else if (we_i) begin
      for (int i = 0; i < NumWeights; i++) begin
        if (idx_i == 3'(i)) begin
          weights_q[i] <= wdata_i;
        end
      end
    end
  end

  assign weights_o = weights_q;

endmodule

// File: rtl/weight_fetch.sv
// Fetch stage of the pedometer pipeline. Accepts clear / count / weight-update
// commands, holds the six model weights, presents one count operation at a
// time to the execute stage and stores the step count written back by it.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         upstream command handshake
//   in_funct, in_A, in_B      command, samples (in_A carries weights in LOAD)
//   out_valid/out_ready       count operation handshake to execute stage
//   funct, A, B               operation presented downstream
//   theta*/alpha*             weight registers
//   totalSteps                current step count
//   wb_valid, updatedSteps    execute-stage writeback
//   err_illegal               one-cycle pulse after an illegal command
module weight_fetch
  import pedo_pkg::*;
#(
  parameter int unsigned   DW    = 10,
  parameter logic [DW-1:0] W_RST = 10'd1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_funct,
  input  logic [DW-1:0] in_A,
  input  logic [DW-1:0] in_B,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    funct,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic [DW-1:0] theta1_1,
  output logic [DW-1:0] theta1_2,
  output logic [DW-1:0] theta2_1,
  output logic [DW-1:0] theta2_2,
  output logic [DW-1:0] alpha1,
  output logic [DW-1:0] alpha2,
  output logic [DW-1:0] totalSteps,
  input  logic          wb_valid,
  input  logic [DW-1:0] updatedSteps,
  output logic          err_illegal
);

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] steps_q, steps_d;
  logic          err_q, err_d;

  logic          wclr;
  logic          wwe;
  logic [NumWeights-1:0][DW-1:0] weights;

  // Only IDLE and LOAD take input; this also enforces a single outstanding count.
  assign in_ready = (state_q == StIdle) || (state_q == StLoad);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    steps_d = steps_q;
    err_d   = 1'b0;
    wclr    = 1'b0;
    wwe     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          case (in_funct)
            FnClr: begin
              wclr    = 1'b1;
              steps_d = '0;
            end
            FnCnt: begin
              a_d     = in_A;
              b_d     = in_B;
              state_d = StIssue;
            end
            FnUpd: begin
              idx_d   = IdxTheta11;
              state_d = StLoad;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      StLoad: begin
        // in_funct is don't-care here: every accepted beat is weight data.
        if (in_valid) begin
          wwe = 1'b1;
          if (idx_q == IdxAlpha2) begin
            idx_d   = IdxTheta11;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StIssue: begin
        if (out_ready) begin
          state_d = StWaitWb;
        end
      end
      StWaitWb: begin
        // Stored as-is: wrap-around is the execute stage's business.
        if (wb_valid) begin
          steps_d = updatedSteps;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= IdxTheta11;
      a_q     <= '0;
      b_q     <= '0;
      steps_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      steps_q <= steps_d;
      err_q   <= err_d;
    end
  end

  weight_regfile #(
    .DW    (DW),
    .W_RST (W_RST)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (wclr),
    .we_i      (wwe),
    .idx_i     (idx_q),
    .wdata_i   (in_A),
    .weights_o (weights)
  );

  assign out_valid   = (state_q == StIssue);
  assign funct       = FnCnt;
  assign A           = a_q;
  assign B           = b_q;
  assign totalSteps  = steps_q;
  assign err_illegal = err_q;

  assign theta1_1 = weights[IdxTheta11];
  assign theta1_2 = weights[IdxTheta12];
  assign theta2_1 = weights[IdxTheta21];
  assign theta2_2 = weights[IdxTheta22];
  assign alpha1   = weights[IdxAlpha1];
  assign alpha2   = weights[IdxAlpha2];

endmodule

// File: tb/tb_weight_fetch.sv
// Directed bench for weight_fetch: load, count handshake, writeback, clear,
// illegal command and reset during LOAD.
module tb_weight_fetch;

  localparam int unsigned DW = 10;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_funct;
  logic [DW-1:0] in_A, in_B;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    funct;
  logic [DW-1:0] A, B;
  logic [DW-1:0] theta1_1, theta1_2, theta2_1, theta2_2, alpha1, alpha2;
  logic [DW-1:0] totalSteps;
  logic          wb_valid;
  logic [DW-1:0] updatedSteps;
  logic          err_illegal;

  int checks   = 0;
  int failures = 0;

  weight_fetch #(
    .DW    (DW),
    .W_RST (10'd1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_funct     (in_funct),
    .in_A         (in_A),
    .in_B         (in_B),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .funct        (funct),
    .A            (A),
    .B            (B),
    .theta1_1     (theta1_1),
    .theta1_2     (theta1_2),
    .theta2_1     (theta2_1),
    .theta2_2     (theta2_2),
    .alpha1       (alpha1),
    .alpha2       (alpha2),
    .totalSteps   (totalSteps),
    .wb_valid     (wb_valid),
    .updatedSteps (updatedSteps),
    .err_illegal  (err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_weights(input string tag, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                               input logic [DW-1:0] w2, input logic [DW-1:0] w3,
                               input logic [DW-1:0] w4, input logic [DW-1:0] w5);
    check({tag, ".theta1_1"}, 32'(theta1_1), 32'(w0));
    check({tag, ".theta1_2"}, 32'(theta1_2), 32'(w1));
    check({tag, ".theta2_1"}, 32'(theta2_1), 32'(w2));
    check({tag, ".theta2_2"}, 32'(theta2_2), 32'(w3));
    check({tag, ".alpha1"},   32'(alpha1),   32'(w4));
    check({tag, ".alpha2"},   32'(alpha2),   32'(w5));
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_funct     = 3'd0;
    in_A         = '0;
    in_B         = '0;
    out_ready    = 1'b0;
    wb_valid     = 1'b0;
    updatedSteps = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.err", 32'(err_illegal), 32'd0);
    check("rst.A", 32'(A), 32'd0);
    check("rst.B", 32'(B), 32'd0);
    check("rst.funct", 32'(funct), 32'd1);
    check("rst.steps", 32'(totalSteps), 32'd0);
    check_weights("rst", 10'd1, 10'd1, 10'd1, 10'd1, 10'd1, 10'd1);

    // Weight update: command then six beats; in_funct=7 during beats is ignored
    in_valid = 1'b1;
    in_funct = 3'd2;
    check("upd.in_ready.cmd", 32'(in_ready), 32'd1);
    step();
    in_funct = 3'd7;
    for (int i = 0; i < 6; i++) begin
      in_A = DW'(5 + i);
      check($sformatf("upd.in_ready.beat%0d", i), 32'(in_ready), 32'd1);
      step();
    end
    in_valid = 1'b0;
    in_funct = 3'd0;
    in_A     = '0;
    check_weights("upd", 10'd5, 10'd6, 10'd7, 10'd8, 10'd9, 10'd10);
    check("upd.err", 32'(err_illegal), 32'd0);
    check("upd.idle", 32'(in_ready), 32'd1);

    // Count with three stalled cycles
    in_valid  = 1'b1;
    in_funct  = 3'd1;
    in_A      = 10'd100;
    in_B      = 10'd200;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    in_A     = 10'd3;
    in_B     = 10'd4;
    for (int i = 0; i < 3; i++) begin
      wb_valid     = (i == 1);
      updatedSteps = 10'd99;
      check($sformatf("cnt.out_valid.%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("cnt.A.%0d", i), 32'(A), 32'd100);
      check($sformatf("cnt.B.%0d", i), 32'(B), 32'd200);
      check($sformatf("cnt.funct.%0d", i), 32'(funct), 32'd1);
      check($sformatf("cnt.in_ready.%0d", i), 32'(in_ready), 32'd0);
      step();
    end
    wb_valid = 1'b0;
    check("cnt.steps_ignore_wb", 32'(totalSteps), 32'd0);
    check("cnt.out_valid.hs", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("cnt.out_valid.after", 32'(out_valid), 32'd0);
    check("cnt.in_ready.wait", 32'(in_ready), 32'd0);
    check("cnt.theta1_1.stable", 32'(theta1_1), 32'd5);

    // Writeback, then a stray writeback in IDLE
    wb_valid     = 1'b1;
    updatedSteps = 10'd42;
    step();
    wb_valid = 1'b0;
    check("wb.steps", 32'(totalSteps), 32'd42);
    check("wb.in_ready", 32'(in_ready), 32'd1);
    wb_valid     = 1'b1;
    updatedSteps = 10'd7;
    step();
    wb_valid = 1'b0;
    check("wb.stray", 32'(totalSteps), 32'd42);

    // Clear
    in_valid = 1'b1;
    in_funct = 3'd0;
    step();
    in_valid = 1'b0;
    check_weights("clr", 10'd1, 10'd1, 10'd1, 10'd1, 10'd1, 10'd1);
    check("clr.steps", 32'(totalSteps), 32'd0);
    check("clr.in_ready", 32'(in_ready), 32'd1);

    // Illegal command
    in_valid = 1'b1;
    in_funct = 3'd5;
    step();
    in_valid = 1'b0;
    in_funct = 3'd0;
    check("ill.err", 32'(err_illegal), 32'd1);
    check("ill.in_ready", 32'(in_ready), 32'd1);
    check("ill.out_valid", 32'(out_valid), 32'd0);
    step();
    check("ill.err.pulse", 32'(err_illegal), 32'd0);

    // Reset after the third LOAD beat, with a count command pending under reset
    in_valid = 1'b1;
    in_funct = 3'd2;
    step();
    for (int i = 0; i < 3; i++) begin
      in_A = DW'(11 + i);
      step();
    end
    rst      = 1'b1;
    in_funct = 3'd1;
    in_A     = 10'd14;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    check_weights("rstload", 10'd1, 10'd1, 10'd1, 10'd1, 10'd1, 10'd1);
    check("rstload.out_valid", 32'(out_valid), 32'd0);
    check("rstload.in_ready", 32'(in_ready), 32'd1);

    // Normal count afterwards; a lingering LOAD would write theta2_2 instead
    in_valid  = 1'b1;
    in_funct  = 3'd1;
    in_A      = 10'd3;
    in_B      = 10'd4;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("post.out_valid", 32'(out_valid), 32'd1);
    check("post.A", 32'(A), 32'd3);
    check("post.B", 32'(B), 32'd4);
    check("post.theta2_2", 32'(theta2_2), 32'd1);
    step();
    out_ready = 1'b0;
    check("post.out_valid.after", 32'(out_valid), 32'd0);
    wb_valid     = 1'b1;
    updatedSteps = 10'd1023;
    step();
    wb_valid = 1'b0;
    check("post.steps", 32'(totalSteps), 32'd1023);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_fetch.md
WEIGHT_FETCH -- requirements
Module: weight_fetch

Interface
REQ-001 Parameter: DW, 10, data width of samples, weights and step count.
REQ-002 Parameter: W_RST, 10'd1, reset/clear value of all six weights.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  upstream command valid.
REQ-006 in_ready  out  1  block accepts command/data this cycle.
REQ-007 in_funct  in  3  0 = clear, 1 = count, 2 = update weights; others illegal.
REQ-008 in_A, in_B  in  DW each  X/Y samples (count); in_A carries weight data during LOAD.
REQ-009 out_valid  out  1  count operation presented to execute stage.
REQ-010 out_ready  in  1  execute stage accepts operation.
REQ-011 funct  out  3  always 3'd1 while out_valid.
REQ-012 A, B  out  DW each  registered samples.
REQ-013 theta1_1, theta1_2, theta2_1, theta2_2, alpha1, alpha2  out  DW each  weight registers.
REQ-014 totalSteps  out  DW  current step count.
REQ-015 wb_valid  in  1  execute stage writeback strobe.
REQ-016 updatedSteps  in  DW  writeback step count.
REQ-017 err_illegal  out  1  one-cycle pulse on illegal funct accept.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, ISSUE, WAIT_WB; handshake completes when valid and ready are both high.
REQ-019 in_ready SHALL be high in IDLE and LOAD, low in ISSUE and WAIT_WB.
REQ-020 IDLE, funct 0 accepted: all weights <= W_RST, totalSteps <= 0 next cycle; stay IDLE.
REQ-021 IDLE, funct 1 accepted: A/B registered, out_valid high next cycle (1-cycle latency); go ISSUE.
REQ-022 IDLE, funct 2 accepted: load index <= 0; go LOAD.
REQ-023 LOAD: each accepted beat writes in_A to weight[index] in order theta1_1, theta1_2, theta2_1, theta2_2, alpha1, alpha2; in_funct ignored; after 6th beat go IDLE.
REQ-024 Weight outputs SHALL update only on a LOAD beat or clear; stable during ISSUE/WAIT_WB.
REQ-025 ISSUE: out_valid, A, B, funct held stable until out_ready; on handshake go WAIT_WB, out_valid low next cycle.
REQ-026 WAIT_WB: on wb_valid, totalSteps <= updatedSteps; go IDLE.
REQ-027 wb_valid outside WAIT_WB SHALL be ignored.
REQ-028 Illegal funct (3..7) in IDLE: accepted, no state change, err_illegal pulses 1 cycle.
REQ-029 totalSteps is not incremented here; wrap 1023->0 is the execute stage's result, stored as-is.
REQ-030 At most one count operation outstanding.

Reset
REQ-031 On rst: state IDLE, load index 0, out_valid 0, err_illegal 0, A/B 0, weights W_RST, totalSteps 0, funct 3'd1.
REQ-032 rst mid-LOAD or mid-ISSUE SHALL abandon operation; partially loaded weights revert to W_RST.
REQ-033 rst has priority over every handshake in the same cycle.

Structure
REQ-034 funct encodings (CLR=0, CNT=1, UPD=2), FSM state encoding and weight-index constants SHALL live in shared package pedo_pkg.
REQ-035 Single module; optional sub-module weight_regfile (6 x DW, indexed write, sync clear).

Verification
REQ-036 rst, then in_funct=2 + 6 beats in_A=5,6,7,8,9,10 -> theta1_1=5 ... alpha2=10; in_ready high all 7 cycles.
REQ-037 funct=1, A=100, B=200, out_ready=0 for 3 cycles -> out_valid/A/B held; in_ready=0; handshake on 4th -> WAIT_WB.
REQ-038 WAIT_WB, wb_valid=1, updatedSteps=42 -> totalSteps=42 next cycle, in_ready=1; stray wb_valid in IDLE with 7 -> totalSteps stays 42.
REQ-039 funct=0 after weights loaded -> all weights=1, totalSteps=0; funct=5 -> err_illegal one-cycle pulse, no state change.
REQ-040 rst asserted after 3rd LOAD beat -> weights all 1, IDLE, out_valid 0; next funct=1 processed normally.
